// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- instruction-decode stage with built-in ID/EX register.
//
// Decodes the IF/ID instruction, reads the internal register file, checks
// the ARM condition field against the status flags, detects RAW hazards
// against the EX and MEM stages, and registers a valid-tagged bundle for EX.
//
// Build option:
//   ID_FORWARD_EN  defined   -> only the load-use case (exMemRead on exDest)
//                               stalls; a forwarding unit resolves the rest
//                               using src1/src2.
//                  undefined -> any EX or MEM write-back to a source stalls.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ifValid/pcIn/inst incoming instruction and its PC+4
//   status            {N,Z,C,V} flags
//   wbWbEn/wbDest/wbValue      register-file write port
//   exWbEn/exMemRead/exDest    EX-stage destination info
//   memWbEn/memDest            MEM-stage destination info
//   flush, exStall    kill the ID instruction / hold the output register
//   idReady           ID accepts the instruction this cycle (combinational)
//   exValid ... src2  registered bundle presented to EX
module id_stage_pipe #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifValid,
   input  logic [DATA_W-1:0]     pcIn,
   input  logic [31:0]           inst,
   input  logic [3:0]            status,
   input  logic                  wbWbEn,
   input  logic [REG_ADDR_W-1:0] wbDest,
   input  logic [DATA_W-1:0]     wbValue,
   input  logic                  exWbEn,
   input  logic                  exMemRead,
   input  logic [REG_ADDR_W-1:0] exDest,
   input  logic                  memWbEn,
   input  logic [REG_ADDR_W-1:0] memDest,
   input  logic                  flush,
   input  logic                  exStall,
   output logic                  idReady,
   output logic                  exValid,
   output logic [DATA_W-1:0]     pcOut,
   output logic [3:0]            aluCmd,
   output logic                  memRead,
   output logic                  memWrite,
   output logic                  wbEn,
   output logic                  branch,
   output logic                  s,
   output logic [DATA_W-1:0]     regRn,
   output logic [DATA_W-1:0]     regRm,
   output logic                  imm,
   output logic [11:0]           shiftOperand,
   output logic [23:0]           imm24,
   output logic [REG_ADDR_W-1:0] dest,
   output logic [REG_ADDR_W-1:0] src1,
   output logic [REG_ADDR_W-1:0] src2
);
   localparam int NREG = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] rf_reg [NREG];

   logic [1:0] mode;
   logic [3:0] opcode;
   logic [3:0] cond;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       cond_pass;
   logic [3:0] dec_alu;
   logic       dec_mr, dec_mw, dec_wb, dec_br, dec_s;
   logic       is_str, two_src, use_src1;
   logic [REG_ADDR_W-1:0] src1_addr, src2_addr;
   logic [DATA_W-1:0]     rn_val, rm_val;
   logic       src1_hit, src2_hit, hazard;

   assign mode   = inst[27:26];
   assign opcode = inst[24:21];
   assign cond   = inst[31:28];
   assign {flag_n, flag_z, flag_c, flag_v} = status;

   // Register file: plain write port, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
      end else if (wbWbEn) begin
         rf_reg[wbDest] <= wbValue;
      end
   end

   // Operation decode (independent of the condition check).
   always_comb begin
      dec_alu = 4'b0000;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_wb  = 1'b0;
      dec_br  = 1'b0;
      dec_s   = 1'b0;
      case (mode)
         2'b00: begin
            dec_wb = 1'b1;
            dec_s  = inst[20];
            case (opcode)
               4'b1101: dec_alu = 4'b0001;                    // MOV
               4'b1111: dec_alu = 4'b1001;                    // MVN
               4'b0100: dec_alu = 4'b0010;                    // ADD
               4'b0101: dec_alu = 4'b0011;                    // ADC
               4'b0010: dec_alu = 4'b0100;                    // SUB
               4'b0110: dec_alu = 4'b0101;                    // SBC
               4'b0000: dec_alu = 4'b0110;                    // AND
               4'b1100: dec_alu = 4'b0111;                    // ORR
               4'b0001: dec_alu = 4'b1000;                    // EOR
               4'b1010: begin dec_alu = 4'b0100; dec_wb = 1'b0; end  // CMP
               4'b1000: begin dec_alu = 4'b0110; dec_wb = 1'b0; end  // TST
               default: begin dec_wb = 1'b0; dec_s = 1'b0; end
            endcase
         end
         2'b01: begin
            dec_alu = 4'b0010;
            if (inst[20]) begin
               dec_mr = 1'b1;
               dec_wb = 1'b1;
            end else begin
               dec_mw = 1'b1;
            end
         end
         2'b10: dec_br = 1'b1;
         default: ;
      endcase
   end

   // ARM condition evaluation; 1111 never executes.
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Source selection: a store reads its data register through src2.
   assign is_str    = (mode == 2'b01) & ~inst[20];
   assign two_src   = (~inst[25] & (mode == 2'b00)) | is_str;
   assign use_src1  = (mode != 2'b10);
   assign src1_addr = inst[16 +: REG_ADDR_W];
   assign src2_addr = is_str ? inst[12 +: REG_ADDR_W] : inst[0 +: REG_ADDR_W];

   // Write-through: a same-cycle write-back is visible to the read.
   assign rn_val = (wbWbEn && wbDest == src1_addr) ? wbValue : rf_reg[src1_addr];
   assign rm_val = (wbWbEn && wbDest == src2_addr) ? wbValue : rf_reg[src2_addr];

`ifdef ID_FORWARD_EN
   logic unused_fwd;
   assign unused_fwd = ^{exWbEn, memWbEn, memDest};
   assign src1_hit = exMemRead && (exDest == src1_addr);
   assign src2_hit = exMemRead && (exDest == src2_addr);
`else
   logic unused_fwd;
   assign unused_fwd = exMemRead;
   assign src1_hit = (exWbEn && exDest == src1_addr) || (memWbEn && memDest == src1_addr);
   assign src2_hit = (exWbEn && exDest == src2_addr) || (memWbEn && memDest == src2_addr);
`endif

   assign hazard  = ifValid & ((use_src1 & src1_hit) | (two_src & src2_hit));
   assign idReady = ~hazard & ~exStall;

   // ID/EX register. Flush overrides a stall so a killed instruction never
   // lingers in the register. Data fields load on bubbles too (don't-care).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exValid      <= 1'b0;
         pcOut        <= '0;
         aluCmd       <= 4'b0000;
         memRead      <= 1'b0;
         memWrite     <= 1'b0;
         wbEn         <= 1'b0;
         branch       <= 1'b0;
         s            <= 1'b0;
         regRn        <= '0;
         regRm        <= '0;
         imm          <= 1'b0;
         shiftOperand <= '0;
         imm24        <= '0;
         dest         <= '0;
         src1         <= '0;
         src2         <= '0;
      end else if (!(exStall && !flush)) begin
         pcOut        <= pcIn;
         regRn        <= rn_val;
         regRm        <= rm_val;
         imm          <= inst[25];
         shiftOperand <= inst[11:0];
         imm24        <= inst[23:0];
         dest         <= inst[12 +: REG_ADDR_W];
         src1         <= src1_addr;
         src2         <= src2_addr;
         if (flush || hazard || !ifValid) begin
            exValid  <= 1'b0;
            aluCmd   <= 4'b0000;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            wbEn     <= 1'b0;
            branch   <= 1'b0;
            s        <= 1'b0;
         end else begin
            // A failed condition still issues, but as a no-op.
            exValid  <= 1'b1;
            aluCmd   <= cond_pass ? dec_alu : 4'b0000;
            memRead  <= cond_pass & dec_mr;
            memWrite <= cond_pass & dec_mw;
            wbEn     <= cond_pass & dec_wb;
            branch   <= cond_pass & dec_br;
            s        <= cond_pass & dec_s;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized
// traffic compared against a behavioural model of the decode stage.
module tb_id_stage_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        ifValid;
   logic [31:0] pcIn, inst;
   logic [3:0]  status;
   logic        wbWbEn;
   logic [3:0]  wbDest;
   logic [31:0] wbValue;
   logic        exWbEn, exMemRead;
   logic [3:0]  exDest;
   logic        memWbEn;
   logic [3:0]  memDest;
   logic        flush, exStall;
   logic        idReady, exValid;
   logic [31:0] pcOut;
   logic [3:0]  aluCmd;
   logic        memRead, memWrite, wbEn, branch, s;
   logic [31:0] regRn, regRm;
   logic        imm;
   logic [11:0] shiftOperand;
   logic [23:0] imm24;
   logic [3:0]  dest, src1, src2;

   int total = 0;
   int bad   = 0;

   id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .ifValid(ifValid), .pcIn(pcIn), .inst(inst),
      .status(status), .wbWbEn(wbWbEn), .wbDest(wbDest), .wbValue(wbValue),
      .exWbEn(exWbEn), .exMemRead(exMemRead), .exDest(exDest),
      .memWbEn(memWbEn), .memDest(memDest), .flush(flush), .exStall(exStall),
      .idReady(idReady), .exValid(exValid), .pcOut(pcOut), .aluCmd(aluCmd),
      .memRead(memRead), .memWrite(memWrite), .wbEn(wbEn), .branch(branch),
      .s(s), .regRn(regRn), .regRm(regRm), .imm(imm),
      .shiftOperand(shiftOperand), .imm24(imm24), .dest(dest),
      .src1(src1), .src2(src2)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] mrf [16];
   // ALU command by data-processing opcode; -1 marks an unsupported opcode.
   int alu_tab [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

   logic        e_valid, e_mr, e_mw, e_wb, e_br, e_s, e_imm;
   logic [3:0]  e_alu, e_dest, e_src1, e_src2;
   logic [31:0] e_pc, e_rn, e_rm;
   logic [11:0] e_shift;
   logic [23:0] e_imm24;

`ifdef ID_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Condition pairs: even code tests a predicate, odd code its inverse.
   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] st);
      bit n, z, cf, v, b;
      {n, z, cf, v} = st;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cf;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cf && !z;
         3'd5: b = (n == v);
         3'd6: b = !z && (n == v);
         default: b = 1'b1;
      endcase
      return c[0] ? !b : b;
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] r);
      if (wbWbEn && wbDest == r) return wbValue;
      return mrf[r];
   endfunction

   function automatic logic [3:0] m_src2();
      return (inst[27:26] == 2'b01 && !inst[20]) ? inst[15:12] : inst[3:0];
   endfunction

   function automatic bit m_hazard();
      logic [3:0] srcs[$];
      if (!ifValid) return 1'b0;
      if (inst[27:26] != 2'b10) srcs.push_back(inst[19:16]);
      if ((inst[27:26] == 2'b00 && !inst[25]) || (inst[27:26] == 2'b01 && !inst[20]))
         srcs.push_back(m_src2());
      foreach (srcs[k]) begin
         if (FWD) begin
            if (exMemRead && exDest == srcs[k]) return 1'b1;
         end else begin
            if ((exWbEn && exDest == srcs[k]) || (memWbEn && memDest == srcs[k])) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      return !m_hazard() && !exStall;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mrf[i] = '0;
      {e_valid, e_mr, e_mw, e_wb, e_br, e_s, e_imm} = '0;
      {e_alu, e_dest, e_src1, e_src2} = '0;
      {e_pc, e_rn, e_rm} = '0;
      e_shift = '0;
      e_imm24 = '0;
   endtask

   // Predicts the register contents for the coming edge, then clocks it.
   task automatic advance();
      bit hz;
      int a;
      hz = m_hazard();
      if (!(exStall && !flush)) begin
         e_pc    = pcIn;
         e_rn    = m_read(inst[19:16]);
         e_rm    = m_read(m_src2());
         e_imm   = inst[25];
         e_shift = inst[11:0];
         e_imm24 = inst[23:0];
         e_dest  = inst[15:12];
         e_src1  = inst[19:16];
         e_src2  = m_src2();
         {e_alu, e_mr, e_mw, e_wb, e_br, e_s} = '0;
         e_valid = 1'b0;
         if (!flush && !hz && ifValid) begin
            e_valid = 1'b1;
            if (m_cond(inst[31:28], status)) begin
               if (inst[27:26] == 2'b00) begin
                  a = alu_tab[inst[24:21]];
                  if (a >= 0) begin
                     e_alu = 4'(a);
                     e_s   = inst[20];
                     e_wb  = !(inst[24:21] == 4'b1010 || inst[24:21] == 4'b1000);
                  end
               end else if (inst[27:26] == 2'b01) begin
                  e_alu = 4'd2;
                  e_mr  = inst[20];
                  e_mw  = !inst[20];
                  e_wb  = inst[20];
               end else if (inst[27:26] == 2'b10) begin
                  e_br = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
      if (wbWbEn) mrf[wbDest] = wbValue;
      #1;
   endtask

   task automatic set_idle();
      ifValid = 0; pcIn = 0; inst = 0; status = 0;
      wbWbEn = 0; wbDest = 0; wbValue = 0;
      exWbEn = 0; exMemRead = 0; exDest = 0;
      memWbEn = 0; memDest = 0; flush = 0; exStall = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      set_idle();
      model_reset();
      #12;
      total++;
      if ({exValid, memRead, memWrite, wbEn, branch, s, aluCmd} !== 10'd0) begin
         bad++; $display("FAIL reset_ctrl got=%h want=0", {exValid, memRead, memWrite, wbEn, branch, s, aluCmd});
      end
      total++;
      if ({pcOut, regRn, regRm, src1, src2, dest} !== 108'd0) begin
         bad++; $display("FAIL reset_data pc=%h rn=%h rm=%h src1=%h src2=%h want all 0", pcOut, regRn, regRm, src1, src2);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if (idReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", idReady); end
      $display("test_reset done");
   endtask

   task automatic test_wb_bypass();
      set_idle();
      ifValid = 1; inst = 32'hE0821003; pcIn = 32'h100;       // ADD R1,R2,R3
      wbWbEn = 1; wbDest = 2; wbValue = 32'h55;
      advance();
      total++;
      if (regRn !== 32'h55) begin bad++; $display("FAIL bypass_rn got=%h want=00000055", regRn); end
      total++;
      if ({exValid, wbEn, aluCmd, pcOut} !== {1'b1, 1'b1, 4'b0010, 32'h100}) begin
         bad++; $display("FAIL bypass_ctrl valid=%b wb=%b alu=%h pc=%h want 1 1 2 100", exValid, wbEn, aluCmd, pcOut);
      end
      wbWbEn = 0;
      advance();
      total++;
      if (regRn !== 32'h55) begin bad++; $display("FAIL rf_written got=%h want=00000055", regRn); end
      $display("test_wb_bypass done");
   endtask

   task automatic test_raw_stall();
      set_idle();
      ifValid = 1; inst = 32'hE0821003; exWbEn = 1; exDest = 3;
      #1;
      total++;
      if (idReady !== FWD) begin bad++; $display("FAIL raw_ex_ready got=%b want=%b", idReady, FWD); end
      advance();
      total++;
      if (exValid !== FWD) begin bad++; $display("FAIL raw_ex_valid got=%b want=%b", exValid, FWD); end
      exWbEn = 0; memWbEn = 1; memDest = 2;
      #1;
      total++;
      if (idReady !== FWD) begin bad++; $display("FAIL raw_mem_ready got=%b want=%b", idReady, FWD); end
      // Immediate form has no second source; branches have none at all.
      memWbEn = 0; exWbEn = 1; exDest = 3; inst = 32'hE2821003;
      #1;
      total++;
      if (idReady !== 1'b1) begin bad++; $display("FAIL raw_imm_ready got=%b want=1", idReady); end
      exDest = 0; inst = 32'hEA000003;
      #1;
      total++;
      if (idReady !== 1'b1) begin bad++; $display("FAIL raw_branch_ready got=%b want=1", idReady); end
      advance();
      total++;
      if ({exValid, branch, aluCmd, wbEn} !== {1'b1, 1'b1, 4'b0000, 1'b0}) begin
         bad++; $display("FAIL branch_ctrl valid=%b br=%b alu=%h wb=%b want 1 1 0 0", exValid, branch, aluCmd, wbEn);
      end
      $display("test_raw_stall done");
   endtask

   task automatic test_load_use();
      set_idle();
      ifValid = 1; inst = 32'hE2845001;                        // ADD R5,R4,#1
      exWbEn = 1; exMemRead = 1; exDest = 4;
      #1;
      total++;
      if (idReady !== 1'b0) begin bad++; $display("FAIL loaduse_ready got=%b want=0", idReady); end
      advance();
      total++;
      if (exValid !== 1'b0) begin bad++; $display("FAIL loaduse_bubble got=%b want=0", exValid); end
      exWbEn = 0; exMemRead = 0;
      #1;
      total++;
      if (idReady !== 1'b1) begin bad++; $display("FAIL loaduse_release got=%b want=1", idReady); end
      advance();
      total++;
      if ({exValid, wbEn, aluCmd, dest, imm, shiftOperand} !== {1'b1, 1'b1, 4'b0010, 4'd5, 1'b1, 12'h001}) begin
         bad++; $display("FAIL loaduse_issue valid=%b wb=%b alu=%h dest=%h imm=%b sh=%h want 1 1 2 5 1 001",
                         exValid, wbEn, aluCmd, dest, imm, shiftOperand);
      end
      $display("test_load_use done");
   endtask

   task automatic test_cond();
      set_idle();
      ifValid = 1; inst = 32'h00821003; status = 4'b0000;     // ADDEQ, Z=0
      advance();
      total++;
      if ({exValid, memRead, memWrite, wbEn, branch, s, aluCmd} !== {1'b1, 9'd0}) begin
         bad++; $display("FAIL cond_fail got=%h want=200", {exValid, memRead, memWrite, wbEn, branch, s, aluCmd});
      end
      status = 4'b0100;
      advance();
      total++;
      if ({exValid, wbEn, aluCmd} !== {1'b1, 1'b1, 4'b0010}) begin
         bad++; $display("FAIL cond_pass valid=%b wb=%b alu=%h want 1 1 2", exValid, wbEn, aluCmd);
      end
      $display("test_cond done");
   endtask

   task automatic test_stall_flush();
      set_idle();
      ifValid = 1; inst = 32'hE0517002; pcIn = 32'h200;       // SUBS R7,R1,R2
      advance();
      total++;
      if ({exValid, aluCmd, s, dest} !== {1'b1, 4'b0100, 1'b1, 4'd7}) begin
         bad++; $display("FAIL stall_setup valid=%b alu=%h s=%b dest=%h want 1 4 1 7", exValid, aluCmd, s, dest);
      end
      exStall = 1; inst = 32'hE3A0000F; pcIn = 32'h204;       // MOV R0,#15
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (idReady !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", c, idReady); end
         advance();
         total++;
         if ({exValid, aluCmd, s, dest, pcOut} !== {1'b1, 4'b0100, 1'b1, 4'd7, 32'h200}) begin
            bad++; $display("FAIL stall_hold cyc=%0d valid=%b alu=%h s=%b dest=%h pc=%h want 1 4 1 7 200",
                            c, exValid, aluCmd, s, dest, pcOut);
         end
      end
      flush = 1;
      advance();
      total++;
      if ({exValid, memRead, memWrite, wbEn, branch, s, aluCmd} !== 10'd0) begin
         bad++; $display("FAIL flush_bubble got=%h want=0", {exValid, memRead, memWrite, wbEn, branch, s, aluCmd});
      end
      flush = 0; exStall = 0; ifValid = 0;
      advance();
      total++;
      if (exValid !== 1'b0) begin bad++; $display("FAIL flush_no_replay got=%b want=0", exValid); end
      $display("test_stall_flush done");
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = bad;
      for (int n = 0; n < 400; n++) begin
         ifValid   = ($urandom_range(0, 9) < 8);
         inst      = $urandom;
         if ($urandom_range(0, 1) == 1) inst[31:28] = 4'hE;
         pcIn      = $urandom;
         status    = 4'($urandom);
         wbWbEn    = ($urandom_range(0, 1) == 1);
         wbDest    = 4'($urandom);
         wbValue   = $urandom;
         exWbEn    = ($urandom_range(0, 3) == 0);
         exMemRead = ($urandom_range(0, 3) == 0);
         exDest    = 4'($urandom);
         memWbEn   = ($urandom_range(0, 3) == 0);
         memDest   = 4'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         exStall   = ($urandom_range(0, 6) == 0);
         #1;
         total++;
         if (idReady !== m_ready()) begin
            bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, idReady, m_ready());
         end
         advance();
         total++;
         if ({exValid, memRead, memWrite, wbEn, branch, s, aluCmd} !== {e_valid, e_mr, e_mw, e_wb, e_br, e_s, e_alu}) begin
            bad++; $display("FAIL rand_ctrl n=%0d got=%h want=%h", n,
                            {exValid, memRead, memWrite, wbEn, branch, s, aluCmd},
                            {e_valid, e_mr, e_mw, e_wb, e_br, e_s, e_alu});
         end
         if (e_valid) begin
            total++;
            if ({pcOut, regRn, regRm} !== {e_pc, e_rn, e_rm}) begin
               bad++; $display("FAIL rand_data n=%0d pc=%h rn=%h rm=%h want pc=%h rn=%h rm=%h",
                               n, pcOut, regRn, regRm, e_pc, e_rn, e_rm);
            end
            total++;
            if ({imm, shiftOperand, imm24, dest, src1, src2} !== {e_imm, e_shift, e_imm24, e_dest, e_src1, e_src2}) begin
               bad++; $display("FAIL rand_fields n=%0d got=%h want=%h", n,
                               {imm, shiftOperand, imm24, dest, src1, src2},
                               {e_imm, e_shift, e_imm24, e_dest, e_src1, e_src2});
            end
         end
      end
      $display("test_random done new_errors=%0d", bad - errs_before);
   endtask

   task automatic test_reset_mid_stall();
      set_idle();
      ifValid = 1; inst = 32'hE0821003; pcIn = 32'h300;
      wbWbEn = 1; wbDest = 3; wbValue = 32'hABCD;
      advance();
      wbWbEn = 0; exStall = 1; inst = 32'hE0517002;
      advance();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      total++;
      if ({exValid, memRead, memWrite, wbEn, branch, s, aluCmd} !== 10'd0) begin
         bad++; $display("FAIL midreset_ctrl got=%h want=0", {exValid, memRead, memWrite, wbEn, branch, s, aluCmd});
      end
      total++;
      if ({pcOut, regRn, regRm, src1, src2} !== 104'd0) begin
         bad++; $display("FAIL midreset_data pc=%h rn=%h rm=%h want 0", pcOut, regRn, regRm);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      set_idle();
      #1;
      total++;
      if (idReady !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", idReady); end
      advance();
      total++;
      if (exValid !== 1'b0) begin bad++; $display("FAIL midreset_pending got=%b want=0", exValid); end
      ifValid = 1; inst = 32'hE0831003;                        // ADD R1,R3,R3
      advance();
      total++;
      if ({exValid, regRn, regRm} !== {1'b1, 64'd0}) begin
         bad++; $display("FAIL midreset_r3 valid=%b rn=%h rm=%h want 1 0 0", exValid, regRn, regRm);
      end
      $display("test_reset_mid_stall done");
   endtask

   initial begin
      test_reset();
      test_wb_bypass();
      test_raw_stall();
      test_load_use();
      test_cond();
      test_stall_flush();
      test_random();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised instruction-decode stage for the ARM-subset 5-stage pipeline, with the ID/EX pipeline register built in. It decodes the IF/ID instruction, reads an internal register file, checks the condition field against the status flags and detects RAW hazards against the EX and MEM stages. It presents a registered, valid-tagged bundle to EX. It also adds stall, flush and bubble handling, plus an optional forwarding-aware hazard mode.

## Interface
Parameters:
- DATA_W, 32, register and PC data width.
- REG_ADDR_W, 4, register address width; the file holds 2**REG_ADDR_W registers.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- ifValid  in  1  inst/pcIn hold a real instruction.
- pcIn  in  DATA_W  PC+4 of the instruction.
- inst  in  32  instruction word.
- status  in  4  {N,Z,C,V} flags from EX.
- wbWbEn  in  1  write-back enable.
- wbDest  in  REG_ADDR_W  write-back register.
- wbValue  in  DATA_W  write-back data.
- exWbEn, exMemRead  in  1 each  EX-stage instruction writes back / is a load.
- exDest  in  REG_ADDR_W  EX-stage destination.
- memWbEn  in  1  MEM-stage instruction writes back.
- memDest  in  REG_ADDR_W  MEM-stage destination.
- flush  in  1  taken branch; kill the instruction in ID.
- exStall  in  1  EX cannot accept; hold the output register.
- idReady  out  1  ID accepts the instruction this cycle; IF and IF/ID advance only when 1.
- exValid  out  1  output bundle is a real instruction.
- pcOut  out  DATA_W  registered pcIn.
- aluCmd  out  4  ALU command.
- memRead, memWrite, wbEn, branch, s  out  1 each  control bits.
- regRn, regRm  out  DATA_W  operands.
- imm  out  1  inst[25].
- shiftOperand  out  12  inst[11:0].
- imm24  out  24  inst[23:0].
- dest  out  REG_ADDR_W  inst[12 +: REG_ADDR_W].
- src1, src2  out  REG_ADDR_W  registered source addresses, for the forwarding unit.

## Operation
- Decode by mode inst[27:26]:
  - 00 data-processing, opcode inst[24:21] to aluCmd, wbEn=1:
    - MOV 1101 to 0001; MVN 1111 to 1001.
    - ADD 0100 to 0010; ADC 0101 to 0011.
    - SUB 0010 to 0100; SBC 0110 to 0101.
    - AND 0000 to 0110; ORR 1100 to 0111; EOR 0001 to 1000.
    - CMP 1010 to 0100 with wbEn=0; TST 1000 to 0110 with wbEn=0.
    - s follows inst[20].
  - 01 memory, aluCmd=0010, s=0:
    - inst[20]=1 is LDR: memRead=1, wbEn=1.
    - inst[20]=0 is STR: memWrite=1, wbEn=0.
  - 10 branch: branch=1, all other control bits 0.
  - Undefined opcode or mode 11: all control bits 0.
- Condition: standard ARM cond encodings 0000–1110 evaluated on status; 1111 is never. A failed condition zeroes all control bits, but exValid still follows ifValid.
- Sources:
  - src1 = inst[19:16].
  - src2 = inst[15:12] for STR, otherwise inst[3:0].
  - twoSrc = (~imm & mode==00) | STR.
  - Branch uses no sources.
- Register file:
  - Reads are combinational.
  - Write on the rising edge when wbWbEn=1.
  - Write-through bypass: a read of wbDest while wbWbEn=1 returns wbValue.
  - All registers clear to 0 on reset.
- Hazard, when ifValid:
  - A source matches exDest with exWbEn=1, or memDest with memWbEn=1.
  - src2 is compared only when twoSrc; branch is never hazarded.
- idReady = ~hazard & ~exStall.
- Output register update priority, highest first:
  1. exStall=1 and flush=0: hold.
  2. flush=1: load bubble.
  3. hazard or ifValid=0: load bubble.
  4. Otherwise: load the decoded bundle with exValid=1.
- Bubble = exValid=0 and all control bits 0. Data fields hold don't-care values, and the bench must not check them.

## Timing
- Latency: 1 cycle from an accepted instruction to valid outputs.
- Reset: every output register is 0 (exValid, control bits, operands, pcOut, src1/src2); register file is 0. Reset asserted mid-stall clears immediately, and state holds no pending instruction afterwards.
- idReady is combinational in the same cycle; IF must sample it before its edge.
- flush together with exStall: flush wins, the register loads a bubble and the killed instruction is not re-presented.
- Write-back and read of the same register in the same cycle: the new value is seen.

## Configuration
- ID_FORWARD_EN defined: the EX/MEM RAW stall is suppressed; only the load-use case stalls (match on exDest with exMemRead=1). Forwarding selects operands using src1/src2.
- Undefined: full RAW stall as above.

## Test plan
- Reset low mid-run → all outputs 0 and idReady=1 after release; R3 reads 0.
- wbWbEn=1, wbDest=2, wbValue=0x55, while decoding ADD R1,R2,R3 in the same cycle → next cycle regRn=0x55, aluCmd=0010, wbEn=1, exValid=1.
- ADD R1,R2,R3 with exDest=3, exWbEn=1:
  - Without macro: idReady=0 and a bubble is issued.
  - With ID_FORWARD_EN: no stall.
- LDR R4 in EX (exMemRead=1, exDest=4) then ADD R5,R4,#1 → one bubble in both configurations, issued the next cycle.
- ADDEQ with status Z=0 → exValid=1 with all control bits 0; with Z=1, aluCmd=0010 and wbEn=1.
- exStall=1 for 3 cycles, then flush → outputs held unchanged for 3 cycles, then exValid=0.
